// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if: requester command/response channels plus the shared APB master bus
interface apb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          req_write;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ*DATA_W/8-1:0] req_strb;
    logic [N_REQ*3-1:0]        req_prot;
    logic [N_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W/8-1:0]       PSTRB;
    logic [2:0]                PPROT;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter sharing one APB master port among N_REQ requesters,
// with IDLE/SETUP/ACCESS sequencing, one-cycle response pulses and a bounded PREADY wait.
module apb_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic           PCLK,
    input logic           PRESET,
    apb_arbiter_if.master bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int SW = DATA_W / 8;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [GW-1:0] last;
    logic [GW-1:0] g;
    logic [CW-1:0] cnt;
    logic          any;
    logic          expire;
    int            j;

    // Scan downward so the lowest offset after last is the final winner.
    always_comb begin
        g = '0;
        j = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(last) + 1 + k) % N_REQ;
            if (bus.req_valid[j]) g = GW'(j);
        end
    end

    assign any           = |bus.req_valid;
    assign expire        = (TIMEOUT != 0) && (cnt == LIM) && !bus.PREADY;
    assign bus.req_ready = (state == IDLE && !PRESET && any) ? N_REQ'(1) << g : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= IDLE;
            last          <= GW'(N_REQ - 1);
            cnt           <= '0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
            bus.PPROT     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                IDLE: if (any) begin
                    state      <= SETUP;
                    last       <= g;
                    bus.PSEL   <= 1'b1;
                    bus.PWRITE <= bus.req_write[g];
                    bus.PADDR  <= bus.req_addr[g*ADDR_W +: ADDR_W];
                    bus.PWDATA <= bus.req_wdata[g*DATA_W +: DATA_W];
                    bus.PSTRB  <= bus.req_write[g] ? bus.req_strb[g*SW +: SW] : '0;
                    bus.PPROT  <= bus.req_prot[g*3 +: 3];
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.PENABLE <= 1'b1;
                end
                ACCESS: if (bus.PREADY || expire) begin
                    state         <= IDLE;
                    cnt           <= '0;
                    bus.PSEL      <= 1'b0;
                    bus.PENABLE   <= 1'b0;
                    bus.rsp_valid <= N_REQ'(1) << last;
                    bus.rsp_rdata <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
                    bus.rsp_err   <= !bus.PREADY || bus.PSLVERR;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: randomized requesters and APB slave checked against a cycle-level
// reference model of the arbitration and transfer timing rules, with a response scoreboard.
module tb_apb_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    logic clk = 0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   errs = 0;

    bit          chk_en = 0;
    bit          auto_en = 0;
    int          dens = 0;
    int          force_w = 0;
    bit          force_rd_en = 0;
    logic [31:0] force_rd = '0;
    int          err_mode = 1;

    logic [N-1:0] rr_seen = '0;
    bit           m_act = 0;
    int           m_t = 0, m_acc = 0, m_w = 0, m_last = N - 1;
    logic [31:0]  m_rd = '0;
    logic         m_err = 0;
    logic [71:0]  m_cmd = '0;
    rsp_t         q[$];

    apb_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration and bus timing derived from the grant cycle and wait count.
    always @(negedge clk) begin
        int          eg;
        logic [N-1:0] exp_rr;
        bit          ep, pe, wr;
        rsp_t        e;
        #1;
        rr_seen = bus.req_ready;
        if (!chk_en) begin
            m_act = 0;
            m_last = N - 1;
            q.delete();
        end else begin
            eg = -1;
            if (!rst && (!m_act || cyc >= m_t + 2 + m_acc))
                for (int k = N - 1; k >= 0; k--)
                    if (bus.req_valid[(m_last + 1 + k) % N]) eg = (m_last + 1 + k) % N;
            exp_rr = '0;
            if (eg >= 0) exp_rr[eg] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rr);
            ep = m_act && cyc >= m_t + 1 && cyc <= m_t + 1 + m_acc;
            pe = m_act && cyc >= m_t + 2 && cyc <= m_t + 1 + m_acc;
            chk("psel", bus.PSEL, ep);
            chk("penable", bus.PENABLE, pe);
            if (ep) chk("bus_cmd", {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT}, m_cmd);
            if (eg >= 0) begin
                wr = bus.req_write[eg];
                m_cmd = {wr, bus.req_addr[eg*AW +: AW], bus.req_wdata[eg*DW +: DW],
                         wr ? bus.req_strb[eg*SW +: SW] : 4'h0, bus.req_prot[eg*3 +: 3]};
                m_w = force_w >= 0 ? force_w :
                      ($urandom_range(3) == 0 ? int'($urandom_range(TO + 1, TO - 2)) : int'($urandom_range(3)));
                m_acc = m_w >= TO ? TO : m_w + 1;
                m_rd = force_rd_en ? force_rd : $urandom;
                m_err = err_mode == 1 ? 1'b0 : err_mode == 2 ? (eg == 1) : 1'($urandom % 2);
                e.idx = eg;
                e.cyc = cyc + 2 + m_acc;
                e.err = m_w >= TO ? 1'b1 : m_err;
                e.rdata = (m_w >= TO || wr) ? 32'h0 : m_rd;
                q.push_back(e);
                m_t = cyc;
                m_act = 1;
                m_last = eg;
            end
            if (rst) begin
                m_act = 0;
                m_last = N - 1;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        rsp_t         e;
        logic [N-1:0] oh;
        if (chk_en) begin
            if (bus.rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, '0);
                end else begin
                    e = q.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    chk("rsp_valid", bus.rsp_valid, oh);
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", bus.rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else if (q.size() != 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 0, e.cyc);
            end
        end
    end

    task automatic new_cmd(int i);
        bus.req_write[i] = 1'($urandom % 2);
        bus.req_addr[i*AW +: AW] = $urandom;
        bus.req_wdata[i*DW +: DW] = $urandom;
        bus.req_strb[i*SW +: SW] = 4'($urandom);
        bus.req_prot[i*3 +: 3] = 3'($urandom);
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic issue(int i, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [2:0] p);
        bus.req_write[i] = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req_strb[i*SW +: SW] = s;
        bus.req_prot[i*3 +: 3] = p;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (rr_seen[i]) bus.req_valid[i] = 1'b0;
        if (auto_en)
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && $urandom_range(99) < dens) new_cmd(i);
        if (m_act && cyc >= m_t + 2 && cyc < m_t + 2 + m_acc) begin
            bus.PREADY = (cyc - m_t - 2) == m_w;
            bus.PRDATA = m_rd;
            bus.PSLVERR = m_err;
        end else begin
            bus.PREADY = 1'($urandom % 2);
            bus.PRDATA = $urandom;
            bus.PSLVERR = 1'($urandom % 2);
        end
    endtask

    task automatic drain;
        int n = 0;
        while ((q.size() != 0 || bus.req_valid != '0) && n < 400) begin
            step();
            n++;
        end
        chk("drain", {96'(q.size()), 32'(bus.req_valid)}, '0);
    endtask

    initial begin
        rst = 1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_strb = '0;
        bus.req_prot = '0;
        bus.PRDATA = '0;
        bus.PREADY = 0;
        bus.PSLVERR = 0;
        step();
        step();
        chk_en = 1;
        step();
        @(negedge clk);
        #2;
        chk("reset_state", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB,
                            bus.PPROT, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, '0);
        step();
        rst = 0;

        err_mode = 1;
        force_w = 0;
        issue(2, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
        drain();

        force_w = 3;
        force_rd_en = 1;
        force_rd = 32'h12345678;
        issue(1, 0, 32'h20, 32'h55, 4'hF, 3'b010);
        drain();

        rst = 1;
        step();
        rst = 0;
        force_rd_en = 0;
        force_w = 0;
        err_mode = 2;
        auto_en = 1;
        dens = 100;
        repeat (15) step();
        auto_en = 0;
        drain();

        err_mode = 0;
        force_w = TO;
        issue(3, 0, 32'h30, 32'h0, 4'h3, 3'b001);
        issue(0, 1, 32'h34, 32'hA5A5A5A5, 4'hC, 3'b100);
        drain();

        force_w = TO - 1;
        issue(1, 0, 32'h40, 32'h0, 4'hF, 3'b011);
        drain();

        force_w = TO;
        issue(2, 1, 32'h50, 32'h11111111, 4'hF, 3'b000);
        repeat (6) step();
        rst = 1;
        step();
        rst = 0;
        force_w = 0;
        issue(3, 1, 32'h60, 32'h22222222, 4'h1, 3'b000);
        issue(0, 0, 32'h64, 32'h0, 4'hF, 3'b000);
        drain();

        force_w = -1;
        err_mode = 0;
        auto_en = 1;
        for (int b = 0; b < 10; b++) begin
            dens = int'($urandom_range(100, 5));
            repeat (200) step();
        end
        auto_en = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Shares a single APB master port between `N_REQ` local requesters. Each requester presents a command over a valid/ready handshake. A round-robin arbiter grants one requester at a time, and an IDLE/SETUP/ACCESS state machine sequences the APB transfer. The block returns read data and the error status to the granted requester as a one-cycle response pulse, and aborts a transfer that stalls past a bounded wait.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width (multiple of 8)
- `TIMEOUT`, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `PCLK` in 1, clock; all state updates on the rising edge
- `PRESET` in 1, synchronous reset, active-high
- `req_valid` in N_REQ, command valid per requester
- `req_ready` out N_REQ, command accepted (one-hot, combinational)
- `req_write` in N_REQ, 1 = write
- `req_addr` in N_REQ*ADDR_W, packed addresses; requester i occupies slice i
- `req_wdata` in N_REQ*DATA_W, packed write data
- `req_strb` in N_REQ*DATA_W/8, packed write strobes
- `req_prot` in N_REQ*3, packed protection attributes
- `rsp_valid` out N_REQ, one-hot, one-cycle completion pulse
- `rsp_rdata` out DATA_W, read data, valid with `rsp_valid`
- `rsp_err` out 1, PSLVERR or timeout, valid with `rsp_valid`
- `PSEL`, `PENABLE`, `PWRITE` out 1; `PADDR` out ADDR_W; `PWDATA` out DATA_W; `PSTRB` out DATA_W/8; `PPROT` out 3; all registered
- `PRDATA` in DATA_W, `PREADY` in 1, `PSLVERR` in 1

## Operation
- **States:** IDLE, SETUP, ACCESS. Reset forces IDLE.
- **Reset values:**
  - All registered outputs are 0.
  - The round-robin pointer `last` is set to N_REQ-1, so requester 0 has first priority.
  - `req_ready` is 0 while PRESET=1.
- **IDLE, arbitration:**
  - If any `req_valid` is set, grant g = the first index at or after (last+1) mod N_REQ with `req_valid[g]`=1.
  - Assert `req_ready[g]` in the same cycle.
  - On the edge: latch the command into the APB output registers, set `last`=g, drive PSEL=1, and go to SETUP.
  - Outside IDLE, `req_ready` is all 0.
- **Read commands:** PSTRB is driven as 0. PWDATA takes the latched `req_wdata`.
- **SETUP:** PSEL=1, PENABLE=0. Unconditionally go to ACCESS with PENABLE=1.
- **ACCESS, normal completion:** PSEL=1, PENABLE=1, with PADDR, PWRITE, PWDATA, PSTRB and PPROT held stable. When PREADY=1:
  - Register `rsp_valid[g]`=1.
  - Register `rsp_rdata`=PRDATA on reads and 0 on writes.
  - Register `rsp_err`=PSLVERR.
  - Clear PSEL/PENABLE and go to IDLE.
- **ACCESS, timeout:** a wait counter counts ACCESS cycles with PREADY=0. If the counter equals TIMEOUT-1 and PREADY=0:
  - Abort: clear PSEL/PENABLE, register `rsp_valid[g]`=1, `rsp_err`=1, `rsp_rdata`=0, and go to IDLE.
  - If PREADY=1 in the limit cycle, normal completion wins.
  - The counter clears on leaving ACCESS.
- **Requester obligations:** hold the command stable and `req_valid` high until `req_ready`. Dropping `req_valid` early is illegal; the block does not check it.
- **Response outputs:** `rsp_valid` is high for exactly one cycle. `rsp_rdata`/`rsp_err` hold their value until the next response.
- **Reset mid-transfer:** PRESET in SETUP or ACCESS returns to IDLE next edge with PSEL=PENABLE=0. No `rsp_valid` is issued for the aborted transfer.

## Timing
- **Grant to bus:** accept cycle T (IDLE, `req_ready`). PSEL rises at T+1 (SETUP). PENABLE rises at T+2 (ACCESS).
- **Zero-wait transfer:** PREADY=1 at T+2 gives `rsp_valid` at T+3. The block is back in IDLE at T+3 and may accept the next command in that same cycle.
- **Throughput:** one transfer per 3 cycles at zero wait states.
- **Wait states:** each cycle of PREADY=0 in ACCESS adds one cycle of latency.
- **Timeout bound:** ACCESS lasts at most TIMEOUT cycles, and timeout `rsp_valid` appears the cycle after the last ACCESS cycle.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 transfers.

## Test plan
- **Single write, zero wait:** requester 2 writes addr 0x10, data 0xDEADBEEF, strb 0xF. Expect `req_ready[2]` at T, PSEL at T+1, PENABLE at T+2, `rsp_valid`=4'b0100 at T+3, `rsp_err`=0, PSTRB=0xF on the bus.
- **Read with 3 wait states:** PREADY low for 3 ACCESS cycles, then high with PRDATA=0x12345678. Expect `rsp_valid` at T+6, `rsp_rdata`=0x12345678, PSTRB=0 throughout.
- **All four requesters valid continuously:** expect grant order 0,1,2,3,0 with one grant every 3 cycles. Also drive PSLVERR=1 on the transfer for requester 1 and expect `rsp_err`=1 only on that response.
- **Timeout:** with TIMEOUT=16 and PREADY held 0, expect exactly 16 ACCESS cycles, then PSEL=0, `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0. The next command is accepted in the following cycle.
- **Timeout boundary:** PREADY=1 in exactly the 16th ACCESS cycle. Expect normal completion with `rsp_err`=PSLVERR.
- **Reset in ACCESS:** assert PRESET for one cycle. Expect PSEL=PENABLE=0 the next cycle, no `rsp_valid`, and requester 0 granted first afterwards.
